// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side burst drain engine.
// D_SIZE of the engine must equal DATA_W here so the buffer entry layout matches.
package fifo_rd_pkg;

   localparam int BUF_DEPTH = 2;
   localparam int DATA_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } rd_entry_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry output buffer; push lands one cycle before the word is visible, simultaneous push/pop holds occ.
// Caller must not push when full or pop when empty; the head stays stable until popped.
module rd_skid_buf
   import fifo_rd_pkg::*;
(
   input  logic      r_clk,
   input  logic      r_rst,
   input  logic      push,
   input  rd_entry_t push_ent,
   input  logic      pop,
   output rd_entry_t head_ent,
   output logic [1:0] occ
);

   rd_entry_t ent [BUF_DEPTH];
   logic      wr_ptr;
   logic      rd_ptr;

   always_ff @(posedge r_clk) begin
      if (push) begin
         ent[wr_ptr] <= push_ent;
      end
   end

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   assign head_ent = ent[rd_ptr];

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst drain engine: pops cmd_len FIFO words and streams them out with an end marker; first word 1 cycle after pop.
// out_ready stalls only the 2-entry buffer; r_inc never depends on out_ready, so the FIFO read path stays registered.
module fifo_burst_reader
   import fifo_rd_pkg::*;
#(
   parameter int D_SIZE = DATA_W,
   parameter int LEN_W  = 8
) (
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic              r_empty,
   input  logic [D_SIZE-1:0] r_data,
   output logic              r_inc,
   input  logic              cmd_valid,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              cmd_ready,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [D_SIZE-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              done_abort,
   output logic [LEN_W-1:0]  words_rd
);

   rd_state_t        state;
   rd_state_t        state_nxt;
   logic [LEN_W-1:0] rem;
   logic             abort_flg;
   logic [1:0]       occ;
   logic             hs;
   rd_entry_t        push_ent;
   rd_entry_t        head_ent;

   assign cmd_ready = r_rst && (state == ST_IDLE);
   assign r_inc     = r_rst && (state == ST_RUN) && !r_empty && (rem != '0)
                      && (occ < 2'(BUF_DEPTH)) && !abort;
   assign hs        = out_valid && out_ready;

   assign push_ent.data = r_data;
   assign push_ent.last = (rem == LEN_W'(1));

   rd_skid_buf u_buf (
      .r_clk    (r_clk),
      .r_rst    (r_rst),
      .push     (r_inc),
      .push_ent (push_ent),
      .pop      (hs),
      .head_ent (head_ent),
      .occ      (occ)
   );

   // An aborted burst never reports a last word, even for entries already buffered.
   assign out_valid  = (occ != 2'd0);
   assign out_data   = head_ent.data;
   assign out_last   = out_valid && head_ent.last && !abort_flg;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign done_abort = done && abort_flg;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (cmd_valid) state_nxt = (cmd_len == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (abort || (r_inc && rem == LEN_W'(1))) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (occ == 2'd0 || (occ == 2'd1 && hs)) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         state     <= ST_IDLE;
         rem       <= '0;
         words_rd  <= '0;
         abort_flg <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cmd_ready && cmd_valid) begin
            rem      <= cmd_len;
            words_rd <= '0;
         end else begin
            if (r_inc) rem      <= rem - LEN_W'(1);
            if (hs)    words_rd <= words_rd + LEN_W'(1);
         end
         if (state == ST_RUN && abort) abort_flg <= 1'b1;
         else if (state == ST_DONE)    abort_flg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: FIFO model plus transaction-level reference for fifo_burst_reader.
// Directed scenarios followed by randomized commands, backpressure, aborts, refills and resets.
module tb_fifo_burst_reader;

   logic       r_clk;
   logic       r_rst;
   logic       r_empty;
   logic [7:0] r_data;
   logic       r_inc;
   logic       cmd_valid;
   logic [7:0] cmd_len;
   logic       cmd_ready;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;
   logic       done;
   logic       done_abort;
   logic [7:0] words_rd;

   fifo_burst_reader dut (
      .r_clk      (r_clk),
      .r_rst      (r_rst),
      .r_empty    (r_empty),
      .r_data     (r_data),
      .r_inc      (r_inc),
      .cmd_valid  (cmd_valid),
      .cmd_len    (cmd_len),
      .cmd_ready  (cmd_ready),
      .abort      (abort),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .done_abort (done_abort),
      .words_rd   (words_rd)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // FIFO contents, words popped but not yet delivered, and words seen downstream
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];

   // burst-level reference state
   bit         m_busy, m_done, m_flush, m_abort;
   int         m_len, m_rem, m_deliv;
   logic [7:0] m_words;
   int         n_pops, n_done;
   bit         last_dab;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fifo_refresh();
      r_empty = (fifo_q.size() == 0);
      r_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   // Called just after a falling edge with inputs already driven; checks, models the rising edge, returns after next fall.
   task automatic cycle();
      logic       e_rdy, e_rinc, e_vld, e_last, pop, hs, was_flush;
      logic [7:0] e_dat, w;
      #1;
      e_rdy  = r_rst && !m_busy;
      e_vld  = (exp_q.size() != 0);
      e_dat  = e_vld ? exp_q[0] : 8'h00;
      e_last = e_vld && !m_abort && (m_deliv + 1 == m_len);
      e_rinc = r_rst && m_busy && !m_done && !m_flush && (m_rem > 0)
               && (fifo_q.size() != 0) && (exp_q.size() < 2) && !abort;
      check("cmd_ready",  32'(cmd_ready),  32'(e_rdy));
      check("busy",       32'(busy),       32'(m_busy));
      check("done",       32'(done),       32'(m_done));
      check("done_abort", 32'(done_abort), 32'(m_done && m_abort));
      check("out_valid",  32'(out_valid),  32'(e_vld));
      check("out_last",   32'(out_last),   32'(e_last));
      if (e_vld) check("out_data", 32'(out_data), 32'(e_dat));
      check("words_rd",   32'(words_rd),   32'(m_words));
      check("r_inc",      32'(r_inc),      32'(e_rinc));
      if (done) begin
         n_done++;
         last_dab = done_abort;
      end
      if (out_valid && out_ready) obs_q.push_back(out_data);
      pop = r_inc && (fifo_q.size() != 0);
      hs  = e_vld && out_ready;
      w   = 8'h00;
      if (pop) begin
         w = fifo_q.pop_front();
         n_pops++;
      end
      was_flush = m_flush;
      if (!r_rst) begin
         exp_q.delete();
         m_busy = 0; m_done = 0; m_flush = 0; m_abort = 0;
         m_rem = 0; m_words = 8'h00;
      end else if (m_done) begin
         m_done = 0; m_busy = 0; m_abort = 0; m_flush = 0;
      end else if (!m_busy) begin
         if (cmd_valid) begin
            m_busy = 1; m_len = int'(cmd_len); m_rem = m_len;
            m_deliv = 0; m_words = 8'h00; m_flush = 0; m_abort = 0;
            m_done = (m_len == 0);
         end
      end else begin
         if (hs) begin
            void'(exp_q.pop_front());
            m_words = m_words + 8'd1;
            m_deliv++;
         end
         if (pop) begin
            exp_q.push_back(w);
            m_rem--;
            if (m_rem == 0) m_flush = 1;
         end
         if (abort && !was_flush && !m_flush) begin
            m_abort = 1;
            m_flush = 1;
         end
         if (was_flush && exp_q.size() == 0) m_done = 1;
      end
      @(posedge r_clk);
      @(negedge r_clk);
      fifo_refresh();
   endtask

   task automatic start(input int len);
      cmd_valid = 1'b1;
      cmd_len   = 8'(len);
      cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic run_to_idle(input int max);
      for (int i = 0; i < max && m_busy; i++) cycle();
      check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic preload(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(base + 8'(i));
      fifo_refresh();
   endtask

   initial begin
      int p0, d0;
      r_rst = 1'b0; cmd_valid = 1'b0; cmd_len = 8'h00; abort = 1'b0; out_ready = 1'b0;
      m_busy = 0; m_done = 0; m_flush = 0; m_abort = 0; m_rem = 0; m_len = 0; m_deliv = 0;
      m_words = 8'h00; n_pops = 0; n_done = 0; last_dab = 0;
      fifo_refresh();
      repeat (2) @(posedge r_clk);
      @(negedge r_clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_done",      32'(done),      32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_words_rd",  32'(words_rd),  32'd0);
      cycle();
      r_rst = 1'b1;
      cycle();

      // plain 4-word burst at full rate
      preload(8'h10, 4);
      out_ready = 1'b1; obs_q.delete(); p0 = n_pops; d0 = n_done;
      start(4);
      run_to_idle(50);
      check("b4_count", 32'(obs_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < obs_q.size(); i++) check("b4_data", 32'(obs_q[i]), 32'h10 + 32'(i));
      check("b4_pops",  32'(n_pops - p0), 32'd4);
      check("b4_done",  32'(n_done - d0), 32'd1);
      check("b4_dab",   32'(last_dab),    32'd0);
      check("b4_words", 32'(words_rd),    32'd4);

      // downstream stall mid-burst
      preload(8'h20, 3);
      obs_q.delete();
      start(3);
      out_ready = 1'b0;
      repeat (5) cycle();
      out_ready = 1'b1;
      run_to_idle(50);
      check("st_count", 32'(obs_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < obs_q.size(); i++) check("st_data", 32'(obs_q[i]), 32'h20 + 32'(i));

      // FIFO runs dry, writer refills later
      preload(8'h30, 1);
      obs_q.delete();
      start(3);
      repeat (10) cycle();
      check("dry_busy", 32'(busy), 32'd1);
      preload(8'h31, 2);
      run_to_idle(50);
      check("dry_count", 32'(obs_q.size()), 32'd3);
      for (int i = 0; i < 3 && i < obs_q.size(); i++) check("dry_data", 32'(obs_q[i]), 32'h30 + 32'(i));

      // abort after 3 pops with 2 words buffered
      preload(8'h40, 8);
      obs_q.delete(); p0 = n_pops; out_ready = 1'b1;
      start(8);
      for (int i = 0; i < 20 && (n_pops - p0) < 3; i++) begin
         if (obs_q.size() >= 1) out_ready = 1'b0;
         cycle();
      end
      abort = 1'b1;
      cycle();
      abort = 1'b0; out_ready = 1'b1;
      run_to_idle(50);
      check("ab_count", 32'(obs_q.size()), 32'd3);
      check("ab_pops",  32'(n_pops - p0),  32'd3);
      check("ab_dab",   32'(last_dab),     32'd1);
      check("ab_words", 32'(words_rd),     32'd3);
      check("ab_left",  32'(fifo_q.size()), 32'd5);
      fifo_q.delete();
      fifo_refresh();

      // zero-length command
      p0 = n_pops;
      start(0);
      #1;
      check("z_done", 32'(done), 32'd1);
      cycle();
      check("z_ready", 32'(cmd_ready), 32'd1);
      check("z_pops",  32'(n_pops - p0), 32'd0);

      // reset with a full buffer
      preload(8'h50, 4);
      out_ready = 1'b0;
      start(3);
      for (int i = 0; i < 10 && exp_q.size() < 2; i++) cycle();
      r_rst = 1'b0;
      cycle();
      r_rst = 1'b1;
      #1;
      check("rr_valid", 32'(out_valid), 32'd0);
      check("rr_busy",  32'(busy),      32'd0);
      check("rr_words", 32'(words_rd),  32'd0);
      check("rr_ready", 32'(cmd_ready), 32'd1);
      check("rr_left",  32'(fifo_q.size()), 32'd2);
      fifo_q.delete();
      fifo_refresh();
      cycle();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_len   = 8'($urandom_range(0, 9));
         abort     = ($urandom_range(0, 40) == 0);
         r_rst     = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 32) fifo_q.push_back(8'($urandom));
         fifo_refresh();
         cycle();
      end
      cmd_valid = 1'b0; abort = 1'b0; out_ready = 1'b1; r_rst = 1'b1;
      for (int i = 0; i < 200 && m_busy; i++) begin
         if (fifo_q.size() == 0) fifo_q.push_back(8'($urandom));
         fifo_refresh();
         cycle();
      end
      check("final_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
